// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the two-master memory arbiter.
package dm_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [3:0] BYTEEN_READ = 4'b0000;

  // Master index: 0 selects m0, 1 selects m1.
  typedef logic m_idx_t;
  localparam m_idx_t M0 = 1'b0;
  localparam m_idx_t M1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick; ptr holds the last granted master and the caller
// loads gnt_idx into it whenever a grant is taken.
module rr_arb2
  import dm_arb_pkg::*;
(
  input  logic [1:0] req,
  input  m_idx_t     ptr,
  output m_idx_t     gnt_idx,
  output logic       any
);

  always_comb begin
    gnt_idx = M0;
    if (req == 2'b11) begin
      gnt_idx = (ptr == M0) ? M1 : M0;
    end else if (req[1]) begin
      gnt_idx = M1;
    end
  end

  assign any = |req;

endmodule

// File: rtl/dm_arbiter.sv
// Two-master arbiter onto one synchronous memory port; fixed two-cycle
// latency (gnt, then rvalid) and round-robin on ties.
//
// state  | meaning
// IDLE   | no access in flight; arbitrate on any req
// ACCESS | drive memory for the latched winner, pulse its gnt
// RESP   | return captured data with rvalid; arbitrate again
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [3:0]        m0_byteen,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [3:0]        m1_byteen,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_byteen,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t            state_q, state_d;
  m_idx_t            ptr_q, win_q, gnt_idx;
  logic              any, load;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        byteen_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  logic              is_read;

  rr_arb2 u_rr (
    .req     ({m1_req, m0_req}),
    .ptr     (ptr_q),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  assign is_read = (byteen_q == BYTEEN_READ);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      ptr_q    <= M1;
      win_q    <= M0;
      addr_q   <= '0;
      byteen_q <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        ptr_q    <= gnt_idx;
        win_q    <= gnt_idx;
        addr_q   <= (gnt_idx == M1) ? m1_addr   : m0_addr;
        byteen_q <= (gnt_idx == M1) ? m1_byteen : m0_byteen;
        wdata_q  <= (gnt_idx == M1) ? m1_wdata  : m0_wdata;
      end
      if (state_q == ACCESS) begin
        rdata_q <= is_read ? mem_rdata : '0;
      end
    end
  end

  // Outputs decode purely from state, so an async reset silences them at once.
  always_comb begin
    state_d    = state_q;
    load       = 1'b0;
    m0_gnt     = 1'b0;
    m1_gnt     = 1'b0;
    m0_rvalid  = 1'b0;
    m1_rvalid  = 1'b0;
    m0_rdata   = '0;
    m1_rdata   = '0;
    mem_addr   = '0;
    mem_byteen = '0;
    mem_wdata  = '0;
    mem_re     = 1'b0;
    case (state_q)
      IDLE: begin
        if (any) begin
          state_d = ACCESS;
          load    = 1'b1;
        end
      end
      ACCESS: begin
        state_d    = RESP;
        m0_gnt     = (win_q == M0);
        m1_gnt     = (win_q == M1);
        mem_addr   = addr_q & ~ADDR_W'(3);
        mem_byteen = byteen_q;
        mem_wdata  = wdata_q;
        mem_re     = is_read;
      end
      RESP: begin
        m0_rvalid = (win_q == M0);
        m1_rvalid = (win_q == M1);
        m0_rdata  = (win_q == M0) ? rdata_q : '0;
        m1_rdata  = (win_q == M1) ? rdata_q : '0;
        if (any) begin
          state_d = ACCESS;
          load    = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
